// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Package : stream_pkg
// Shared constants and width helpers for the N:1 stream multiplexer.
// Rev     : 1.0
// ============================================================================
package stream_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel-index width; never zero so a 1-channel index still has a bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_n_1_if.sv
`default_nettype none
// ============================================================================
// Interface : stream_mux_n_1_if
// Input streams, select and output stream of the N:1 stream multiplexer.
// Rev       : 1.0
// ============================================================================
interface stream_mux_n_1_if
  import stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SELW = sel_width(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SELW-1:0]           out_chan;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational rotating-priority arbiter; search starts at ptr and wraps.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [N-1:0]  w_rot;
  logic [SELW:0] w_pos;
  logic          w_found;

  // w_rot[k] is the request of channel (ptr + k) mod N.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_pos   = {1'b0, ptr} + (SELW+1)'(k);
      end
    end
    if (w_pos >= (SELW+1)'(N)) w_pos = w_pos - (SELW+1)'(N);
    grant_idx = w_pos[SELW-1:0];
    grant     = w_found ? (N'(1) << grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module : stream_mux_n_1
// N:1 valid/ready stream mux with one registered output stage; steered or RR.
// Rev    : 1.0
// ============================================================================
module stream_mux_n_1
  import stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_SEL
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_n_1_if.slave bus
);

  localparam int              SELW   = sel_width(CHANNELS);
  localparam logic [SELW-1:0] C_LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]     r_ptr;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_chan;
  logic                r_out_valid;

  logic [CHANNELS-1:0] w_sel_grant;
  logic [CHANNELS-1:0] w_rr_grant;
  logic [CHANNELS-1:0] w_grant;
  logic [CHANNELS-1:0] w_ready;
  logic [SELW-1:0]     w_rr_idx;
  logic [SELW-1:0]     w_grant_idx;
  logic [WIDTH-1:0]    w_mux_data;
  logic                w_load_en;
  logic                w_xfer;

  // Out-of-range sel values match no channel, so they never grant.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_dec
    assign w_sel_grant[i] = bus.in_valid[i] && (bus.sel == SELW'(i));
  end

  rr_arbiter #(
    .N    (CHANNELS),
    .SELW (SELW)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (r_ptr),
    .grant     (w_rr_grant),
    .grant_idx (w_rr_idx)
  );

  assign w_grant     = (MODE == MODE_RR) ? w_rr_grant : w_sel_grant;
  assign w_grant_idx = (MODE == MODE_RR) ? w_rr_idx   : bus.sel;
  assign w_load_en   = !r_out_valid || bus.out_ready;
  assign w_ready     = (rst_n && w_load_en) ? w_grant : '0;
  // A grant already implies in_valid, so any ready bit is a transfer.
  assign w_xfer      = |w_ready;

  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant[i]) w_mux_data |= bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_chan  <= w_grant_idx;
        if (MODE == MODE_RR) begin
          r_ptr <= (w_grant_idx == C_LAST) ? '0 : w_grant_idx + SELW'(1);
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_mux_n_1
// Self-checking bench: steered (4 and 5 channels) and round-robin instances.
// Rev    : 1.0
// ============================================================================
module tb_stream_mux_n_1;
  import stream_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  chan;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  beat_t       q0[$], q1[$], q5[$];
  logic [31:0] d0[4], d1[4], d5[5];
  logic [31:0] last0_data, last5_data;
  logic [2:0]  last0_chan, last5_chan;
  int          rp;

  always #5 clk = ~clk;

  stream_mux_n_1_if #(.WIDTH(32), .CHANNELS(4)) b0 ();
  stream_mux_n_1_if #(.WIDTH(32), .CHANNELS(4)) b1 ();
  stream_mux_n_1_if #(.WIDTH(32), .CHANNELS(5)) b5 ();

  stream_mux_n_1 #(.WIDTH(32), .CHANNELS(4), .MODE(MODE_SEL)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  stream_mux_n_1 #(.WIDTH(32), .CHANNELS(4), .MODE(MODE_RR))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  stream_mux_n_1 #(.WIDTH(32), .CHANNELS(5), .MODE(MODE_SEL)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic pack_all();
    b0.in_data = {d0[3], d0[2], d0[1], d0[0]};
    b1.in_data = {d1[3], d1[2], d1[1], d1[0]};
    for (int i = 0; i < 5; i++) b5.in_data[i*32 +: 32] = d5[i];
  endtask

  task automatic test_reset();
    b0.in_valid = 4'hF; b0.sel = '0; b0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", b0.out_valid); end
    checks++; if (b0.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", b0.out_data); end
    checks++; if (b0.out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", b0.out_chan); end
    checks++; if (b0.in_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", b0.in_ready); end
    checks++; if (b1.out_valid !== 1'b0 || b5.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_others: got %b%b want 00", b1.out_valid, b5.out_valid); end
    @(negedge clk);
    b0.in_valid = '0; b0.out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sel_steer();
    logic [1:0] sv[5] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd3};
    logic [3:0] vv[5] = '{4'b0110, 4'b0110, 4'b1111, 4'b0110, 4'b1000};
    logic [3:0] exp;
    beat_t b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b0.sel = sv[k]; b0.in_valid = vv[k]; b0.out_ready = 1'b1;
      #1;
      exp = vv[k][sv[k]] ? (4'b0001 << sv[k]) : 4'b0000;
      checks++; if (b0.in_ready !== exp) begin errors++; $display("FAIL sel_ready[%0d]: got %b want %b", k, b0.in_ready, exp); end
      if (exp != 0) begin b.data = d0[sv[k]]; b.chan = 3'(sv[k]); q0.push_back(b); end
      @(posedge clk);
      #1;
      if (exp != 0) begin
        checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL sel_queue[%0d]: scoreboard empty", k); end
        else begin
          b = q0.pop_front();
          if (b0.out_valid !== 1'b1 || b0.out_data !== b.data || b0.out_chan !== b.chan[1:0]) begin
            errors++; $display("FAIL sel_out[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", k, b0.out_valid, b0.out_data, b0.out_chan, b.data, b.chan);
          end
          last0_data = b.data; last0_chan = b.chan;
        end
      end else begin
        checks++;
        if (b0.out_valid !== 1'b0 || b0.out_data !== last0_data || b0.out_chan !== last0_chan[1:0]) begin
          errors++; $display("FAIL sel_bubble[%0d]: got v=%b d=%h c=%0d want v=0 d=%h c=%0d", k, b0.out_valid, b0.out_data, b0.out_chan, last0_data, last0_chan);
        end
      end
    end
  endtask

  task automatic test_sel_range();
    logic [2:0] sv[4] = '{3'd4, 3'd5, 3'd7, 3'd0};
    logic [4:0] exp;
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b5.sel = sv[k]; b5.in_valid = 5'b11111; b5.out_ready = 1'b1;
      #1;
      exp = (sv[k] < 3'd5) ? (5'b00001 << sv[k]) : 5'b00000;
      checks++; if (b5.in_ready !== exp) begin errors++; $display("FAIL range_ready[%0d]: got %b want %b", k, b5.in_ready, exp); end
      if (exp != 0) begin b.data = d5[sv[k]]; b.chan = sv[k]; q5.push_back(b); end
      @(posedge clk);
      #1;
      checks++;
      if (exp != 0) begin
        if (q5.size() == 0) begin errors++; $display("FAIL range_queue[%0d]: scoreboard empty", k); end
        else begin
          b = q5.pop_front();
          if (b5.out_valid !== 1'b1 || b5.out_data !== b.data || b5.out_chan !== b.chan) begin
            errors++; $display("FAIL range_out[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", k, b5.out_valid, b5.out_data, b5.out_chan, b.data, b.chan);
          end
          last5_data = b.data; last5_chan = b.chan;
        end
      end else if (b5.out_valid !== 1'b0 || b5.out_data !== last5_data || b5.out_chan !== last5_chan) begin
        errors++; $display("FAIL range_bubble[%0d]: got v=%b d=%h c=%0d want v=0 d=%h c=%0d", k, b5.out_valid, b5.out_data, b5.out_chan, last5_data, last5_chan);
      end
    end
    @(negedge clk);
    b5.in_valid = '0;
  endtask

  task automatic test_backpressure();
    beat_t b;
    @(negedge clk);
    d0[0] = 32'h11; pack_all();
    b0.sel = 2'd0; b0.in_valid = 4'b0001; b0.out_ready = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 4'b0001) begin errors++; $display("FAIL bp_load_ready: got %b want 0001", b0.in_ready); end
    b.data = 32'h11; b.chan = 3'd0; q0.push_back(b);
    @(posedge clk);
    #1;
    b = q0.pop_front();
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== b.data) begin errors++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=%h", b0.out_valid, b0.out_data, b.data); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b0.out_ready = 1'b0;
      d0[0] = 32'h22; pack_all();
      b0.in_valid = 4'b0011;
      b0.sel = (k == 1) ? 2'd1 : 2'd0;
      #1;
      checks++; if (b0.in_ready !== 4'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, b0.in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== 32'h11 || b0.out_chan !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=11 c=0", k, b0.out_valid, b0.out_data, b0.out_chan);
      end
    end
    @(negedge clk);
    b0.sel = 2'd0; b0.out_ready = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b want 0001", b0.in_ready); end
    b.data = 32'h22; b.chan = 3'd0; q0.push_back(b);
    @(posedge clk);
    #1;
    b = q0.pop_front();
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== b.data) begin errors++; $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=%h", b0.out_valid, b0.out_data, b.data); end
    @(negedge clk);
    b0.in_valid = '0;
    @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b want 0", b0.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] vv[14] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                           4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b1001};
    logic [3:0] exp;
    int g;
    beat_t b;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      b1.in_valid = vv[k]; b1.out_ready = 1'b1;
      #1;
      g = rr_pick(vv[k], rp);
      exp = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checks++; if (b1.in_ready !== exp) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, b1.in_ready, exp); end
      if (g >= 0) begin b.data = d1[g]; b.chan = 3'(g); q1.push_back(b); rp = (g + 1) % 4; end
      @(posedge clk);
      #1;
      checks++;
      if (g >= 0) begin
        if (q1.size() == 0) begin errors++; $display("FAIL rr_queue[%0d]: scoreboard empty", k); end
        else begin
          b = q1.pop_front();
          if (b1.out_valid !== 1'b1 || b1.out_data !== b.data || b1.out_chan !== b.chan[1:0]) begin
            errors++; $display("FAIL rr_out[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", k, b1.out_valid, b1.out_data, b1.out_chan, b.data, b.chan);
          end
        end
      end else if (b1.out_valid !== 1'b0) begin
        errors++; $display("FAIL rr_idle[%0d]: got v=%b want 0", k, b1.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    int g;
    beat_t b;
    @(negedge clk);
    d0[0] = 32'h33; pack_all();
    b0.sel = 2'd0; b0.in_valid = 4'b0001; b0.out_ready = 1'b1;
    b1.in_valid = 4'b0010; b1.out_ready = 1'b1;
    #1;
    g = rr_pick(4'b0010, rp);
    checks++; if (b1.in_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rst_pre_rr_ready: got %b want %b", b1.in_ready, 4'b0001 << g); end
    b.data = d1[g]; b.chan = 3'(g); q1.push_back(b); rp = (g + 1) % 4;
    @(posedge clk);
    #1;
    b = q1.pop_front();
    checks++; if (b1.out_chan !== b.chan[1:0] || b1.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_rr_out: got v=%b c=%0d want v=1 c=%0d", b1.out_valid, b1.out_chan, b.chan); end
    @(negedge clk);
    b0.in_valid = '0; b0.out_ready = 1'b0;
    b1.in_valid = '0; b1.out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 32'h33) begin errors++; $display("FAIL rst_stalled: got v=%b d=%h want v=1 d=33", b0.out_valid, b0.out_data); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    rp = 0;
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_data !== 32'h0 || b0.out_chan !== 2'd0) begin
      errors++; $display("FAIL rst_async: got v=%b d=%h c=%0d want v=0 d=0 c=0", b0.out_valid, b0.out_data, b0.out_chan);
    end
    checks++; if (b1.out_valid !== 1'b0 || b1.out_chan !== 2'd0) begin errors++; $display("FAIL rst_async_rr: got v=%b c=%0d want v=0 c=0", b1.out_valid, b1.out_chan); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b1.in_valid = 4'hF; b1.out_ready = 1'b1;
    #1;
    g = rr_pick(4'hF, rp);
    checks++; if (b1.in_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rst_rr_first_ready: got %b want %b", b1.in_ready, 4'b0001 << g); end
    b.data = d1[g]; b.chan = 3'(g); q1.push_back(b); rp = (g + 1) % 4;
    @(posedge clk);
    #1;
    b = q1.pop_front();
    checks++; if (b1.out_chan !== b.chan[1:0] || b1.out_data !== b.data) begin errors++; $display("FAIL rst_rr_first_out: got c=%0d d=%h want c=%0d d=%h", b1.out_chan, b1.out_data, b.chan, b.data); end
    @(negedge clk);
    b1.in_valid = '0;
  endtask

  initial begin
    d0 = '{32'h0000_1111, 32'h0000_2222, 32'hDEAD_BEEF, 32'h0000_4444};
    d1 = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    d5 = '{32'h5000_0000, 32'h5111_1111, 32'h5222_2222, 32'h5333_3333, 32'h5444_4444};
    pack_all();
    b0.in_valid = '0; b0.sel = '0; b0.out_ready = 1'b0;
    b1.in_valid = '0; b1.sel = '0; b1.out_ready = 1'b0;
    b5.in_valid = '0; b5.sel = '0; b5.out_ready = 1'b0;
    last0_data = '0; last0_chan = '0; last5_data = '0; last5_chan = '0;
    rp = 0;

    test_reset();
    test_sel_steer();
    test_sel_range();
    test_backpressure();
    test_round_robin();
    test_reset_mid_stall();

    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q5.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q5.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/stream_mux_n_1.md
Name: stream_mux_n_1

Overview:
- Parametrised successor to the datapath 2:1 multiplexer.
- Selects one of CHANNELS valid/ready input streams of WIDTH bits and forwards it through a single registered output stage.
- Two modes: externally steered select, or internal round-robin arbitration.
- Used where several producers (writeback sources, memory/IO return paths) share one consumer port and need back-pressure instead of a purely combinational pick.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of input streams (>=2).
- MODE, 0, 0 = select from sel port; 1 = round-robin arbitration (sel ignored).
- SELW, max(1,clog2(CHANNELS)), select/channel-index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- sel  input  SELW  channel select, used in MODE 0 only.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_chan  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_chan=0, rr pointer=0. All in_ready are 0 while rst_n is low.
- load_en = !out_valid || out_ready. Full throughput: one beat per cycle when out_ready is held high.
- Grant, one-hot or zero:
  - MODE 0: grant[sel]=1 iff sel<CHANNELS and in_valid[sel]. sel>=CHANNELS gives no grant and no transfer.
  - MODE 1: grant the first i with in_valid[i], searching ptr, ptr+1, ... modulo CHANNELS.
- in_ready[i] = load_en && grant[i]. Never depends on in_valid of other channels in MODE 0. At most one bit is set.
- Input transfer: in_valid[i] && in_ready[i].
- On a transfer at an edge: out_data <= channel g data, out_chan <= g, out_valid <= 1. In MODE 1, ptr <= (g+1) mod CHANNELS (wraps CHANNELS-1 -> 0).
- No transfer and out_ready=1: out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid && !out_ready): out_data, out_chan and out_valid are held stable; no in_ready asserted.
- Latency: input accepted at edge N appears on out_* after edge N; consumed at the first edge with out_ready=1.
- Simultaneous output drain and input accept in the same cycle: the new beat replaces the old, out_valid stays 1, no bubble.
- sel changes while stalled: no effect until load_en=1. The sel value sampled in the accepting cycle decides the channel.
- No grant in MODE 1: ptr unchanged.
- Reset mid-stall: the buffered beat is discarded and the output is invalid immediately (async).
- No data loss or duplication: each input handshake yields exactly one output handshake, in order.

Decomposition:
- Shared package stream_pkg: function clog2, SELW derivation, MODE_SEL=0 / MODE_RR=1 constants.
- Sub-module rr_arbiter (parameter N; inputs req[N], ptr[SELW]; outputs grant[N], grant_idx[SELW]). Purely combinational priority rotation. The pointer register stays in stream_mux_n_1.
- The output register and the MODE 0 decode live in the top module.

Test Plan:
- MODE 0, CHANNELS=4, WIDTH=32: sel=2, in_valid=4'b0110, in_data[2]=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=2.
- MODE 0: sel=3, in_valid[3]=0 -> in_ready=0 and out_valid drops to 0 after one cycle. sel=5 with CHANNELS=5 gives no grant.
- Back-pressure: out_ready=0 for 3 cycles after a beat 0x11 loads -> out_data stays 0x11, in_ready=0. Raise out_ready with a new beat 0x22 waiting -> 0x22 appears the next cycle, no bubble, no loss.
- MODE 1: all four in_valid held 1, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 (pointer wraps).
- MODE 1, in_valid=4'b1001, ptr=1 -> grant channel 3, then channel 0, then 3.
- Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 without a clock edge. After release in MODE 1 with all valid, first grant is channel 0.
